ball_game_sequencer: RTL and testbench



---
 rtl/ball_game_sequencer.sv | 101 ++++++++++
 tb/tb_ball_game_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ball_game_sequencer.sv
// ball_game_sequencer: attract/serve/play/lost/cleared/over sequencer for the brick-and-paddle game.
// Define LEVEL_PROGRESSION_EN to enable the level counter and the per-level serve shortening.
module ball_game_sequencer #(
    parameter int START_LIVES  = 3,
    parameter int NUM_BRICKS   = 128,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 90,
    parameter int CLEAR_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       ball_out,
    input  logic       brick_hit,
    output logic       ball_hold,
    output logic       ball_enable,
    output logic       clear_bricks,
    output logic       declives,
    output logic [3:0] lives,
    output logic       game_over,
    output logic [2:0] state,
    output logic [2:0] level
);
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, LOST, CLEARED, OVER} state_t;

    state_t     st, nxt;
    logic       vs_q, start_q, frame_tick, start_edge;
    logic [7:0] frame_cnt, bricks_left, wait_n, serve_n;
    logic       wait_done, start_game, hit, cleared, lose, restore;

    assign state = st;

`ifdef LEVEL_PROGRESSION_EN
    int serve_raw;
    assign serve_raw = SERVE_FRAMES - 8 * int'(level);
    assign serve_n   = serve_raw < 1 ? 8'd1 : 8'(serve_raw);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            level <= 3'd0;
        else
            level <= start_game ? 3'd0 : restore ? level + 3'd1 : level;
    end
`else
    assign serve_n = 8'(SERVE_FRAMES);
    assign level   = 3'd0;
`endif

    always_comb begin
        wait_n     = st == SERVE ? serve_n : st == LOST ? 8'(LOST_FRAMES) : 8'(CLEAR_FRAMES);
        wait_done  = frame_tick && frame_cnt == wait_n - 8'd1;
        start_game = start_edge && (st == IDLE || st == OVER);
        hit        = st == PLAY && brick_hit;
        cleared    = hit && bricks_left == 8'd1;
        lose       = st == PLAY && ball_out && !cleared;
        restore    = st == CLEARED && wait_done;
        nxt        = st;
        case (st)
            IDLE, OVER: nxt = start_edge ? SERVE : st;
            SERVE:      nxt = wait_done ? PLAY : st;
            PLAY:       nxt = cleared ? CLEARED : lose ? LOST : st;
            LOST:       nxt = wait_done ? (lives == 4'd0 ? OVER : SERVE) : st;
            CLEARED:    nxt = wait_done ? SERVE : st;
            default:    nxt = IDLE;
        endcase
    end

    // start_q resets high so a start held through reset produces no edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= IDLE;
            vs_q         <= 1'b0;
            start_q      <= 1'b1;
            frame_tick   <= 1'b0;
            start_edge   <= 1'b0;
            frame_cnt    <= 8'd0;
            bricks_left  <= 8'd0;
            lives        <= 4'd0;
            ball_hold    <= 1'b1;
            ball_enable  <= 1'b0;
            clear_bricks <= 1'b0;
            declives     <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            vs_q         <= vsync;
            frame_tick   <= vsync && !vs_q;
            start_q      <= start;
            start_edge   <= start && !start_q;
            st           <= nxt;
            frame_cnt    <= nxt != st ? 8'd0 : frame_tick ? frame_cnt + 8'd1 : frame_cnt;
            ball_hold    <= nxt != PLAY;
            ball_enable  <= nxt == PLAY;
            game_over    <= nxt == OVER;
            clear_bricks <= start_game || restore;
            declives     <= lose;
            lives        <= start_game ? 4'(START_LIVES) : (lose && lives != 4'd0) ? lives - 4'd1 : lives;
            bricks_left  <= (start_game || restore) ? 8'(NUM_BRICKS) :
                            (hit && bricks_left != 8'd0) ? bricks_left - 8'd1 : bricks_left;
        end
    end
endmodule

// File: tb/tb_ball_game_sequencer.sv
// tb_ball_game_sequencer: directed vector table plus hand sequences for the game sequencer.
module tb_ball_game_sequencer;
    localparam logic [2:0] LVL1 =
`ifdef LEVEL_PROGRESSION_EN
        3'd1;
`else
        3'd0;
`endif
    localparam int SERVE_L1 =
`ifdef LEVEL_PROGRESSION_EN
        1;
`else
        2;
`endif

    logic clk = 1'b0, reset = 1'b0;
    logic vsync = 1'b0, start = 1'b0, ball_out = 1'b0, brick_hit = 1'b0;
    logic ball_hold, ball_enable, clear_bricks, declives, game_over;
    logic [3:0] lives;
    logic [2:0] state, level;
    int vecs = 0, errs = 0;

    ball_game_sequencer #(
        .START_LIVES(2), .NUM_BRICKS(4), .SERVE_FRAMES(2), .LOST_FRAMES(3), .CLEAR_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start), .ball_out(ball_out),
        .brick_hit(brick_hit), .ball_hold(ball_hold), .ball_enable(ball_enable),
        .clear_bricks(clear_bricks), .declives(declives), .lives(lives),
        .game_over(game_over), .state(state), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vs, st, bo, bh;
        logic [2:0] es;
        logic [3:0] el;
        logic       ec, ed;
        logic [2:0] elv;
    } vec_t;
    vec_t tv[29];

    task automatic chk(input string nm, input logic [2:0] es, input logic [3:0] el,
                       input logic ec, input logic ed, input logic [2:0] elv);
        logic [14:0] exp_v, act_v;
        exp_v = {es, el, es != 3'd2, es == 3'd2, ec, ed, es == 3'd5, elv};
        act_v = {state, lives, ball_hold, ball_enable, clear_bricks, declives, game_over, level};
        vecs++;
        if (act_v !== exp_v) begin
            errs++;
            $display("FAIL %s: {state,lives,hold,en,clr,dec,over,level} got %b want %b", nm, act_v, exp_v);
        end
    endtask

    task automatic cyc(input logic s, input logic bo, input logic bh);
        @(negedge clk);
        start = s; ball_out = bo; brick_hit = bh; vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tick_frame();
        @(negedge clk); vsync = 1'b1; ball_out = 1'b0; brick_hit = 1'b0;
        @(negedge clk); vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{0,0,0,0, 0,0,0,0,0};
        tv[1]  = '{0,1,0,0, 0,0,0,0,0};
        tv[2]  = '{0,1,0,0, 1,2,1,0,0};
        tv[3]  = '{1,0,0,0, 1,2,0,0,0};
        tv[4]  = '{0,0,0,0, 1,2,0,0,0};
        tv[5]  = '{1,0,0,0, 1,2,0,0,0};
        tv[6]  = '{0,0,0,0, 2,2,0,0,0};
        tv[7]  = '{0,0,1,0, 3,1,0,1,0};
        tv[8]  = '{0,0,1,0, 3,1,0,0,0};
        tv[9]  = '{1,0,0,0, 3,1,0,0,0};
        tv[10] = '{0,0,0,0, 3,1,0,0,0};
        tv[11] = '{1,0,0,0, 3,1,0,0,0};
        tv[12] = '{0,0,0,0, 3,1,0,0,0};
        tv[13] = '{1,0,0,0, 3,1,0,0,0};
        tv[14] = '{0,0,0,0, 1,1,0,0,0};
        tv[15] = '{1,0,0,0, 1,1,0,0,0};
        tv[16] = '{0,0,0,0, 1,1,0,0,0};
        tv[17] = '{1,0,0,0, 1,1,0,0,0};
        tv[18] = '{0,0,0,0, 2,1,0,0,0};
        tv[19] = '{0,0,0,1, 2,1,0,0,0};
        tv[20] = '{0,0,0,0, 2,1,0,0,0};
        tv[21] = '{0,0,0,1, 2,1,0,0,0};
        tv[22] = '{0,0,0,1, 2,1,0,0,0};
        tv[23] = '{0,0,1,1, 4,1,0,0,0};
        tv[24] = '{1,0,0,0, 4,1,0,0,0};
        tv[25] = '{0,0,0,0, 4,1,0,0,0};
        tv[26] = '{1,0,0,0, 4,1,0,0,0};
        tv[27] = '{0,0,0,0, 1,1,1,0,LVL1};
        tv[28] = '{0,0,0,0, 1,1,0,0,LVL1};

        repeat (3) @(posedge clk);
        #1 chk("reset", 0, 0, 0, 0, 0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 29; i++) begin
            if (i > 0) @(negedge clk);
            vsync = tv[i].vs; start = tv[i].st; ball_out = tv[i].bo; brick_hit = tv[i].bh;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), tv[i].es, tv[i].el, tv[i].ec, tv[i].ed, tv[i].elv);
        end

        repeat (SERVE_L1) tick_frame();
        chk("serve_after_level", 2, 1, 0, 0, LVL1);
        cyc(1, 0, 0);
        chk("start_ignored_in_play", 2, 1, 0, 0, LVL1);
        cyc(1, 1, 0);
        chk("last_life_lost", 3, 0, 0, 1, LVL1);
        repeat (3) tick_frame();
        chk("game_over", 5, 0, 0, 0, LVL1);
        tick_frame();
        repeat (3) cyc(1, 0, 0);
        chk("held_start_no_restart", 5, 0, 0, 0, LVL1);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("restart_edge_pending", 5, 0, 0, 0, LVL1);
        cyc(1, 0, 0);
        chk("restart_serve", 1, 2, 1, 0, 0);
        cyc(1, 0, 0);
        chk("restart_clr_one_cycle", 1, 2, 0, 0, 0);

        repeat (2) tick_frame();
        chk("replay", 2, 2, 0, 0, 0);
        repeat (4) cyc(0, 0, 1);
        chk("four_bricks_cleared", 4, 2, 0, 0, 0);
        tick_frame();
        chk("mid_cleared_wait", 4, 2, 0, 0, 0);

        @(posedge clk); #2;
        start = 1'b1; reset = 1'b0;
        #1 chk("async_reset_mid_wait", 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (4) cyc(1, 0, 0);
        chk("start_held_through_reset", 0, 0, 0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("start_after_reset", 1, 2, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
